// File: rtl/result_to_sign_bcd.sv
// Two's-complement result to sign + three BCD digits, by repeated subtraction.
// Optional RESULT_DEC_OVF_EN adds ovf_in/err: an overflowed result reports F/F/F with err set.
module result_to_sign_bcd #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] result,
`ifdef RESULT_DEC_OVF_EN
  input  logic         ovf_in,
  output logic         err,
`endif
  output logic         busy,
  output logic         done,
  output logic         sign,
  output logic [3:0]   hundreds,
  output logic [3:0]   tens,
  output logic [3:0]   units
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] NEGATE = 2'd1;
  localparam logic [1:0] HUND   = 2'd2;
  localparam logic [1:0] TENS   = 2'd3;

  logic [1:0]   state;
  logic [W-1:0] mag;
  logic         sgn;
  logic [3:0]   h_cnt;
  logic [3:0]   t_cnt;
`ifdef RESULT_DEC_OVF_EN
  logic         ovf;
`endif

  // Widened copy so the >=100 test is valid even when W is too narrow to hold 100.
  logic [10:0]  mag_x;
  logic         ge100;
  logic         ge10;
  assign mag_x = 11'(mag);
  assign ge100 = mag_x >= 11'd100;
  assign ge10  = mag_x >= 11'd10;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mag      <= '0;
      sgn      <= 1'b0;
      h_cnt    <= 4'd0;
      t_cnt    <= 4'd0;
      done     <= 1'b0;
      sign     <= 1'b0;
      hundreds <= 4'd0;
      tens     <= 4'd0;
      units    <= 4'd0;
`ifdef RESULT_DEC_OVF_EN
      ovf      <= 1'b0;
      err      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mag   <= result;
            sgn   <= result[W-1];
            h_cnt <= 4'd0;
            t_cnt <= 4'd0;
`ifdef RESULT_DEC_OVF_EN
            ovf   <= ovf_in;
`endif
            state <= NEGATE;
          end
        end
        NEGATE: begin
`ifdef RESULT_DEC_OVF_EN
          if (ovf) begin
            sign     <= 1'b0;
            hundreds <= 4'hF;
            tens     <= 4'hF;
            units    <= 4'hF;
            err      <= 1'b1;
            done     <= 1'b1;
            state    <= IDLE;
          end else begin
            if (sgn) mag <= ~mag + W'(1);
            state <= HUND;
          end
`else
          // W-bit wrap: the most negative value becomes its unsigned magnitude.
          if (sgn) mag <= ~mag + W'(1);
          state <= HUND;
`endif
        end
        HUND: begin
          if (ge100) begin
            mag   <= mag - W'(100);
            h_cnt <= h_cnt + 4'd1;
          end else begin
            state <= TENS;
          end
        end
        TENS: begin
          if (ge10) begin
            mag   <= mag - W'(10);
            t_cnt <= t_cnt + 4'd1;
          end else begin
            sign     <= sgn;
            hundreds <= h_cnt;
            tens     <= t_cnt;
            units    <= mag[3:0];
`ifdef RESULT_DEC_OVF_EN
            err      <= 1'b0;
`endif
            done     <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_to_sign_bcd.sv
// Scoreboard bench: stimulus pushes model results, a negedge monitor pops on done.
module tb_result_to_sign_bcd;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] result = 8'd0;
  logic       busy, done, sign;
  logic [3:0] hundreds, tens, units;
`ifdef RESULT_DEC_OVF_EN
  logic       ovf_in = 1'b0;
  logic       err;
`endif

  result_to_sign_bcd #(.W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .result(result),
`ifdef RESULT_DEC_OVF_EN
    .ovf_in(ovf_in), .err(err),
`endif
    .busy(busy), .done(done), .sign(sign),
    .hundreds(hundreds), .tens(tens), .units(units)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       sgn;
    logic [3:0] h, t, u;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decimal reference from plain integer arithmetic.
  function automatic exp_t model(input logic [7:0] r, input bit ovf, input int e0);
    exp_t e;
    int v, m;
    v = $signed(r);
    m = (v < 0) ? -v : v;
    if (ovf) begin
      e.sgn = 1'b0; e.h = 4'hF; e.t = 4'hF; e.u = 4'hF; e.err = 1'b1; e.cyc = e0 + 1;
    end else begin
      e.sgn = (v < 0);
      e.h = 4'(m / 100);
      e.t = 4'((m % 100) / 10);
      e.u = 4'(m % 10);
      e.err = 1'b0;
      e.cyc = e0 + 3 + m / 100 + (m % 100) / 10;
    end
    return e;
  endfunction

  task automatic issue(input logic [7:0] r, input bit ovf);
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      errors++;
      $display("FAIL issue_timeout: busy stuck high, expected idle within 200 cycles");
    end
    start = 1'b1;
    result = r;
`ifdef RESULT_DEC_OVF_EN
    ovf_in = ovf;
`endif
    @(posedge clk);
    #1;
    q.push_back(model(r, ovf, cyc));
    start = 1'b0;
    result = 8'($urandom);
`ifdef RESULT_DEC_OVF_EN
    ovf_in = 1'($urandom);
`endif
  endtask

  // Monitor: pop and compare on done, also check single-cycle done and stable outputs while busy.
  logic       prev_done = 1'b0;
  logic [12:0] prev_out = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done) begin
        if (q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_done: got done=1 expected no pending conversion (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("digits", {19'd0, sign, hundreds, tens, units}, {19'd0, e.sgn, e.h, e.t, e.u});
          chk("latency", cyc, e.cyc);
`ifdef RESULT_DEC_OVF_EN
          chk("err", {31'd0, err}, {31'd0, e.err});
`endif
        end
      end
      if (done && prev_done) chk("done_pulse", 32'd2, 32'd1);
      if (busy) chk("hold_while_busy", {19'd0, sign, hundreds, tens, units}, {19'd0, prev_out});
    end
    prev_done = done;
    prev_out = {sign, hundreds, tens, units};
  end

  initial begin
    int n;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_digits", {19'd0, sign, hundreds, tens, units}, 32'd0);
`ifdef RESULT_DEC_OVF_EN
    chk("rst_err", {31'd0, err}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    issue(8'd127, 1'b0);
    issue(8'h80, 1'b0);
    issue(8'hFF, 1'b0);
    issue(8'h00, 1'b0);
    issue(8'd16, 1'b0);
    // Start while busy with a different value must be dropped.
    @(negedge clk);
    start = 1'b1; result = 8'd77;
    @(negedge clk);
    start = 1'b0;
    issue(8'd45, 1'b0);
    issue(8'd100, 1'b0);
    issue(8'h9C, 1'b0);

    // Abort mid-conversion: no done afterwards, outputs cleared at once.
    issue(8'd99, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    q.delete();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_digits", {19'd0, sign, hundreds, tens, units}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_done_busy", {31'd0, busy}, 32'd0);

`ifdef RESULT_DEC_OVF_EN
    issue(8'd12, 1'b1);
    issue(8'd12, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
`ifdef RESULT_DEC_OVF_EN
      issue(8'($urandom), ($urandom_range(0, 7) == 0));
`else
      issue(8'($urandom), 1'b0);
`endif
    end

    n = 0;
    while (q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    chk("queue_drained", q.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/result_to_sign_bcd.md
Name: result_to_sign_bcd

Overview:
Return-path converter for the calculator datapath. It takes a two's-complement ALU result and produces a sign flag plus three BCD digits (hundreds/tens/units) for the display driver. It is the inverse of the operand complementing stage: that stage takes coded operands into two's complement, and this block takes the result back into sign-magnitude decimal. It is a sequential FSM with a start/done handshake and uses repeated subtraction, so latency is data-dependent.

Parameters:
W, 8, result width in bits; legal range 4..10, which guarantees magnitude <= 512 and hundreds <= 5.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request conversion of result; sampled only in IDLE.
result  input  W  two's-complement value to convert.
busy  output  1  high while FSM not in IDLE.
done  output  1  one-cycle pulse; output digits valid from this cycle.
sign  output  1  1 = negative result.
hundreds  output  4  BCD hundreds digit.
tens  output  4  BCD tens digit.
units  output  4  BCD units digit.

Behaviour:
- Reset (async, rst high): FSM to IDLE. Work regs cleared. Outputs: busy=0, done=0, sign=0, hundreds=0, tens=0, units=0. Reset mid-conversion aborts with no done pulse.
- Internal state: mag (W bits, unsigned), sgn, h_cnt, t_cnt (4 bits each).
- States and transitions:
  - IDLE: if start, mag<=result, sgn<=result[W-1], h_cnt<=0, t_cnt<=0, go to NEGATE. Otherwise stay.
  - NEGATE: if sgn, mag<=~mag+1 (W-bit wrap, so the most negative value -2^(W-1) yields unsigned 2^(W-1)). Go to HUND.
  - HUND: if mag>=100, mag<=mag-100 and h_cnt<=h_cnt+1, stay. Otherwise go to TENS.
  - TENS: if mag>=10, mag<=mag-10 and t_cnt<=t_cnt+1, stay. Otherwise, on the same edge: sign<=sgn, hundreds<=h_cnt, tens<=t_cnt, units<=mag[3:0], done<=1, go to IDLE.
- done clears on the next edge; it is never high for two consecutive cycles.
- busy is high whenever state != IDLE.
- Latency: call the edge that samples start edge 0, H the hundreds digit and T the tens digit. done is high in the cycle after edge 3+H+T.
- sign/hundreds/tens/units hold their last value until the next done. They do not change while busy.
- start while busy is ignored and not queued. result is sampled only at edge 0, so later changes have no effect.
- start high in the done cycle is accepted because the FSM is already in IDLE. Back-to-back conversions have zero idle gap.
- Zero converts as sign=0, digits 0/0/0. There is no negative zero.

Optional Feature:
Macro RESULT_DEC_OVF_EN.
- Defined: adds input ovf_in (1 bit, sampled with start) and output err (1 bit, reset 0).
  - If ovf_in=1 at start: skip NEGATE/HUND/TENS. On edge 1 set hundreds=tens=units=4'hF, sign=0, err=1, done=1, then return to IDLE.
  - Any conversion with ovf_in=0 sets err=0 when its done is asserted.
- Undefined: no ovf_in/err ports. Behaviour is exactly as above.

Test Plan:
- Reset values: assert rst mid-conversion (result=8'd99 started) -> all outputs 0, busy=0 immediately, no done pulse after release.
- Positive value: result=8'd127, start -> done after edge 6. sign=0, hundreds=1, tens=2, units=7. busy high for 6 cycles.
- Most negative: result=8'h80 (-128) -> done after edge 6. sign=1, hundreds=1, tens=2, units=8.
- Small negative and zero: result=8'hFF -> sign=1, 0/0/1, done after edge 3. result=8'h00 -> sign=0, 0/0/0, done after edge 3.
- Handshake: start pulsed while busy with a different result -> ignored, first result's digits reported. start held high during the done cycle with result=8'd45 -> new conversion accepted, done after edge 7 relative to it, digits 0/4/5.
- With RESULT_DEC_OVF_EN: ovf_in=1, result=8'd12 -> done after edge 1, digits F/F/F, err=1. Next conversion with ovf_in=0 and result=8'd12 -> err=0, digits 0/1/2.
